rename_map: RTL and testbench
=============================

// Module: rename_map
// PURPOSE
//  Register-rename stage, successor of the single-shot map stage. RAT maps logical to physical regs;
//  circular free list allocates dests. Commit port returns old mappings; flush restores the committed
//  state in one cycle. Sits between decode and dispatch, 1-deep registered output, valid/ready both sides.
// PARAMETERS
//  LOG_RF_DEPTH  32   logical registers (x0 hard-wired, never renamed)
//  PHY_RF_DEPTH  128  physical registers; power of 2, > LOG_RF_DEPTH
//  LA = $clog2(LOG_RF_DEPTH), PA = $clog2(PHY_RF_DEPTH)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  in_valid        in   1   uop offered
//  in_ready        out  1   uop accepted when in_valid && in_ready
//  in_rs1/rs2/rd   in   LA  logical regs; in_rs1_valid/in_rs2_valid/in_rd_valid (1 each) qualify them
//  out_valid       out  1   renamed uop held
//  out_ready       in   1   downstream takes it when out_valid && out_ready
//  out_prs1/prs2   out  PA  physical sources (0 if source invalid)
//  out_prd         out  PA  new physical dest (0 if no allocation)
//  out_prd_old     out  PA  previous mapping of rd, freed at commit (0 if no allocation)
//  out_rd_valid    out  1   allocation performed
//  commit_valid    in   1   in-order retirement of one uop with allocation
//  commit_rd       in   LA  retiring logical dest; commit_prd, commit_prd_old in PA
//  flush           in   1   discard all speculative renames
//  free_count      out  PA  free physical regs
//  busy_wr_en      out  1   busy-table write strobe; busy_wr_addr out PA; busy_data_out out 1 (const 1)
// BEHAVIOUR
//  Reset (async, rst_n=0): RAT[i]=CRAT[i]=i; free list entry k = LOG_RF_DEPTH+k for k<PHY-LOG;
//   head=chead=0, tail=PHY-LOG; out_valid=0, all out_* =0, busy_wr_en=0; free_count=PHY-LOG (96).
//  free_count = (tail-head) mod PHY_RF_DEPTH; never reaches PHY_RF_DEPTH, so no full/empty ambiguity.
//  alloc = in_rd_valid && in_rd!=0.
//  in_ready = !flush && (!out_valid || out_ready) && (!alloc || free_count!=0); comb, no in_valid dependence.
//  Accept (1-cycle latency, out_* registered):
//   prs1/prs2 = RAT[rs] read BEFORE this uop's rd update (rs==rd yields old mapping).
//   alloc: prd=freelist[head], prd_old=RAT[rd], RAT[rd]<=prd, head++; busy_wr_en=1,
//    busy_wr_addr=freelist[head] comb in accept cycle. No alloc: prd=prd_old=0, head unchanged.
//  Next uop sees RAT update of previous accept (back-to-back safe).
//  out_valid: set on accept; cleared on out_ready with no new accept; held stable while stalled.
//  Commit (commit_valid && commit_rd!=0): freelist[tail]<=commit_prd_old, tail++,
//   CRAT[commit_rd]<=commit_prd, chead++. commit_rd==0 ignored. Allowed every cycle, incl. during
//   accept/flush; same-cycle commit and allocation both take effect.
//  Flush (priority over accept): RAT<=CRAT incl. same-cycle commit; head<=chead incl. same-cycle increment;
//   out_valid<=0; busy_wr_en=0. Speculative regs in [chead,head) return to pool without copy.
//  Pointers PA bits, wrap modulo PHY_RF_DEPTH. RAT[0]=CRAT[0]=0 always.
//  Reset mid-operation: immediate return to reset state; in-flight uop dropped.
// TESTING
//  1 reset; add x5,x1,x2 -> prs1=1, prs2=2, prd=32, prd_old=5, busy_wr 32, free_count=95.
//  2 x5<-x1; then x6<-x5,x5 -> 2nd uop prs1=prs2=32, prd=33, prd_old=6; rd==rs: x7<-x7 -> prs1=7, prd=34.
//  3 96 allocs -> free_count=0, in_ready=0 for alloc uop, 1 for no-dest uop; commit prd_old=5 -> next prd=5.
//  4 three renames, no commit, flush -> RAT identity, free_count=96, next rd alloc prd=32, out_valid=0.
//  5 rd=x0 / rd_valid=0 -> prd=prd_old=0, busy_wr_en=0, free_count unchanged; out_ready=0 holds out_* stable.
//  6 commit+flush same cycle, and rst_n low mid-stall -> CRAT/head include commit; reset clears async.

Source files
------------

// File: rtl/rename_map_if.sv
`default_nettype none
// ------------------------------------------------------------
// rename_map_if: decode-side and dispatch-side uop handshakes
// Rev 1.0
// ------------------------------------------------------------
interface rename_map_if #(
  parameter int LA = 5,
  parameter int PA = 7
);
  logic          in_valid;
  logic          in_ready;
  logic [LA-1:0] in_rs1;
  logic          in_rs1_valid;
  logic [LA-1:0] in_rs2;
  logic          in_rs2_valid;
  logic [LA-1:0] in_rd;
  logic          in_rd_valid;
  logic          out_valid;
  logic          out_ready;
  logic [PA-1:0] out_prs1;
  logic [PA-1:0] out_prs2;
  logic [PA-1:0] out_prd;
  logic [PA-1:0] out_prd_old;
  logic          out_rd_valid;

  modport slave (
    input  in_valid, in_rs1, in_rs1_valid, in_rs2, in_rs2_valid, in_rd, in_rd_valid, out_ready,
    output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_rd_valid
  );

  modport master (
    output in_valid, in_rs1, in_rs1_valid, in_rs2, in_rs2_valid, in_rd, in_rd_valid, out_ready,
    input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_prd_old, out_rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/rename_map.sv
`default_nettype none
// ------------------------------------------------------------
// rename_map: RAT + circular free list rename stage with commit/flush
// Rev 1.0
// ------------------------------------------------------------
module rename_map #(
  parameter  int LOG_RF_DEPTH = 32,
  parameter  int PHY_RF_DEPTH = 128,
  localparam int LA = $clog2(LOG_RF_DEPTH),
  localparam int PA = $clog2(PHY_RF_DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rename_map_if.slave        bus,
  input  wire logic          commit_valid,
  input  wire logic [LA-1:0] commit_rd,
  input  wire logic [PA-1:0] commit_prd,
  input  wire logic [PA-1:0] commit_prd_old,
  input  wire logic          flush,
  output logic      [PA-1:0] free_count,
  output logic               busy_wr_en,
  output logic      [PA-1:0] busy_wr_addr,
  output logic               busy_data_out
);

  localparam int NFREE = PHY_RF_DEPTH - LOG_RF_DEPTH;

  logic [PA-1:0] r_rat  [LOG_RF_DEPTH];
  logic [PA-1:0] r_crat [LOG_RF_DEPTH];
  logic [PA-1:0] r_fl   [PHY_RF_DEPTH];
  logic [PA-1:0] r_head;
  logic [PA-1:0] r_tail;
  logic [PA-1:0] r_chead;

  logic          r_out_valid;
  logic [PA-1:0] r_out_prs1;
  logic [PA-1:0] r_out_prs2;
  logic [PA-1:0] r_out_prd;
  logic [PA-1:0] r_out_prd_old;
  logic          r_out_rd_valid;

  logic          w_alloc;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_commit;
  logic [PA-1:0] w_chead_nxt;

  assign w_alloc     = bus.in_rd_valid && (bus.in_rd != '0);
  assign free_count  = r_tail - r_head;
  assign w_in_ready  = !flush && (!r_out_valid || bus.out_ready) && (!w_alloc || (free_count != '0));
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_commit    = commit_valid && (commit_rd != '0);
  assign w_chead_nxt = r_chead + PA'(w_commit);

  assign busy_wr_en    = w_accept && w_alloc;
  assign busy_wr_addr  = busy_wr_en ? r_fl[r_head] : '0;
  assign busy_data_out = 1'b1;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_prs1     = r_out_prs1;
  assign bus.out_prs2     = r_out_prs2;
  assign bus.out_prd      = r_out_prd;
  assign bus.out_prd_old  = r_out_prd_old;
  assign bus.out_rd_valid = r_out_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG_RF_DEPTH; i++) begin
        r_rat[i]  <= PA'(i);
        r_crat[i] <= PA'(i);
      end
      for (int k = 0; k < PHY_RF_DEPTH; k++) begin
        r_fl[k] <= (k < NFREE) ? PA'(LOG_RF_DEPTH + k) : '0;
      end
      r_head         <= '0;
      r_chead        <= '0;
      r_tail         <= PA'(NFREE);
      r_out_valid    <= 1'b0;
      r_out_prs1     <= '0;
      r_out_prs2     <= '0;
      r_out_prd      <= '0;
      r_out_prd_old  <= '0;
      r_out_rd_valid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_fl[r_tail]     <= commit_prd_old;
        r_tail           <= r_tail + PA'(1);
        r_crat[commit_rd] <= commit_prd;
        r_chead          <= w_chead_nxt;
      end

      if (flush) begin
        // Restore must see a commit landing in this same cycle.
        for (int i = 0; i < LOG_RF_DEPTH; i++) begin
          r_rat[i] <= (w_commit && (commit_rd == LA'(i))) ? commit_prd : r_crat[i];
        end
        r_head      <= w_chead_nxt;
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid    <= 1'b1;
        r_out_prs1     <= bus.in_rs1_valid ? r_rat[bus.in_rs1] : '0;
        r_out_prs2     <= bus.in_rs2_valid ? r_rat[bus.in_rs2] : '0;
        r_out_prd      <= w_alloc ? r_fl[r_head] : '0;
        r_out_prd_old  <= w_alloc ? r_rat[bus.in_rd] : '0;
        r_out_rd_valid <= w_alloc;
        if (w_alloc) begin
          r_rat[bus.in_rd] <= r_fl[r_head];
          r_head           <= r_head + PA'(1);
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_map.sv
`default_nettype none
// ------------------------------------------------------------
// tb_rename_map: directed scenarios plus random traffic vs a queue-based model
// Rev 1.0
// ------------------------------------------------------------
module tb_rename_map;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       commit_valid;
  logic [4:0] commit_rd;
  logic [6:0] commit_prd;
  logic [6:0] commit_prd_old;
  logic       flush;
  logic [6:0] free_count;
  logic       busy_wr_en;
  logic [6:0] busy_wr_addr;
  logic       busy_data_out;

  always #5 clk = ~clk;

  rename_map_if bus ();

  rename_map dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_prd     (commit_prd),
    .commit_prd_old (commit_prd_old),
    .flush          (flush),
    .free_count     (free_count),
    .busy_wr_en     (busy_wr_en),
    .busy_wr_addr   (busy_wr_addr),
    .busy_data_out  (busy_data_out)
  );

  typedef struct {
    int rd;
    int prd;
    int old;
  } pend_t;

  // Reference model: mapping tables, free pool in allocation order, and
  // the in-flight (uncommitted) allocations in program order.
  int    m_rat[32];
  int    m_crat[32];
  int    free_q[$];
  int    spec_q[$];
  pend_t pend_q[$];
  bit    m_ov;
  int    m_prs1, m_prs2, m_prd, m_old;
  bit    m_rdv;

  int tests = 0;
  int fails = 0;

  bit s_iv, s_v1, s_v2, s_vd, s_ordy, s_cv, s_fl;
  int s_rs1, s_rs2, s_rd, s_crd, s_cprd, s_cold;
  logic last_rdy, last_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rat[i]  = i;
      m_crat[i] = i;
    end
    free_q.delete();
    spec_q.delete();
    pend_q.delete();
    for (int k = 0; k < 96; k++) free_q.push_back(32 + k);
    m_ov = 0; m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0; m_rdv = 0;
  endtask

  task automatic clear_stim();
    s_iv = 0; s_v1 = 0; s_v2 = 0; s_vd = 0; s_ordy = 1; s_cv = 0; s_fl = 0;
    s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_crd = 0; s_cprd = 0; s_cold = 0;
  endtask

  task automatic set_uop(input int rs1, input int rs2, input int rd, input bit ordy);
    clear_stim();
    s_iv = 1; s_v1 = 1; s_v2 = 1; s_vd = 1;
    s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_ordy = ordy;
  endtask

  task automatic commit_front();
    pend_t pe;
    pe = pend_q.pop_front();
    s_cv = 1; s_crd = pe.rd; s_cprd = pe.prd; s_cold = pe.old;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle();
    bit alloc, exp_rdy, acc, cmt;
    int p;
    bus.in_valid     = s_iv;
    bus.in_rs1       = 5'(s_rs1);
    bus.in_rs1_valid = s_v1;
    bus.in_rs2       = 5'(s_rs2);
    bus.in_rs2_valid = s_v2;
    bus.in_rd        = 5'(s_rd);
    bus.in_rd_valid  = s_vd;
    bus.out_ready    = s_ordy;
    commit_valid     = s_cv;
    commit_rd        = 5'(s_crd);
    commit_prd       = 7'(s_cprd);
    commit_prd_old   = 7'(s_cold);
    flush            = s_fl;
    #3;
    alloc   = s_vd && (s_rd != 0);
    exp_rdy = !s_fl && (!m_ov || s_ordy) && (!alloc || free_q.size() != 0);
    acc     = s_iv && exp_rdy;
    cmt     = s_cv && (s_crd != 0);
    last_rdy  = bus.in_ready;
    last_busy = busy_wr_en;
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check_eq("free_count", 32'(free_count), free_q.size());
    check_eq("busy_wr_en", 32'(busy_wr_en), 32'(acc && alloc));
    check_eq("busy_data", 32'(busy_data_out), 1);
    if (acc && alloc) check_eq("busy_wr_addr", 32'(busy_wr_addr), free_q[0]);

    if (acc && !s_fl) begin
      m_prs1 = s_v1 ? m_rat[s_rs1] : 0;
      m_prs2 = s_v2 ? m_rat[s_rs2] : 0;
      m_rdv  = alloc;
      m_prd  = 0;
      m_old  = 0;
      if (alloc) begin
        p = free_q.pop_front();
        m_prd = p;
        m_old = m_rat[s_rd];
        m_rat[s_rd] = p;
        spec_q.push_back(p);
        pend_q.push_back('{rd: s_rd, prd: p, old: m_old});
      end
      m_ov = 1;
    end else if (s_ordy) begin
      m_ov = 0;
    end
    if (cmt) begin
      m_crat[s_crd] = s_cprd;
      free_q.push_back(s_cold);
      void'(spec_q.pop_front());
    end
    if (s_fl) begin
      m_rat  = m_crat;
      free_q = {spec_q, free_q};
      spec_q.delete();
      pend_q.delete();
      m_ov = 0;
    end

    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check_eq("out_prs1", 32'(bus.out_prs1), m_prs1);
    check_eq("out_prs2", 32'(bus.out_prs2), m_prs2);
    check_eq("out_prd", 32'(bus.out_prd), m_prd);
    check_eq("out_prd_old", 32'(bus.out_prd_old), m_old);
    check_eq("out_rd_valid", 32'(bus.out_rd_valid), 32'(m_rdv));
  endtask

  task automatic do_reset();
    clear_stim();
    bus.in_valid = 0; bus.out_ready = 1; commit_valid = 0; flush = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs1_valid = 0; bus.in_rs2 = 0;
    bus.in_rs2_valid = 0; bus.in_rd = 0; bus.in_rd_valid = 0; bus.out_ready = 1;
    commit_valid = 0; commit_rd = 0; commit_prd = 0; commit_prd_old = 0; flush = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state and first rename
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_free_count", 32'(free_count), 96);
    check_eq("rst_out_prd", 32'(bus.out_prd), 0);
    set_uop(1, 2, 5, 1); cycle();
    check_eq("t1_prs1", 32'(bus.out_prs1), 1);
    check_eq("t1_prs2", 32'(bus.out_prs2), 2);
    check_eq("t1_prd", 32'(bus.out_prd), 32);
    check_eq("t1_prd_old", 32'(bus.out_prd_old), 5);
    check_eq("t1_free", 32'(free_count), 95);

    // Back-to-back dependency and rs==rd
    do_reset();
    set_uop(1, 0, 5, 1); s_v2 = 0; cycle();
    set_uop(5, 5, 6, 1); cycle();
    check_eq("t2_prs1", 32'(bus.out_prs1), 32);
    check_eq("t2_prs2", 32'(bus.out_prs2), 32);
    check_eq("t2_prd", 32'(bus.out_prd), 33);
    check_eq("t2_prd_old", 32'(bus.out_prd_old), 6);
    set_uop(7, 0, 7, 1); s_v2 = 0; cycle();
    check_eq("t2_rsrd_prs1", 32'(bus.out_prs1), 7);
    check_eq("t2_rsrd_prd", 32'(bus.out_prd), 34);

    // Exhaust the free list, then recycle a committed mapping
    do_reset();
    for (int i = 0; i < 96; i++) begin
      set_uop(i % 32, (i + 3) % 32, (i == 0) ? 5 : 1 + (i % 31), 1);
      cycle();
    end
    check_eq("t3_free0", 32'(free_count), 0);
    set_uop(1, 2, 9, 1); cycle();
    check_eq("t3_full_rdy", 32'(last_rdy), 0);
    set_uop(1, 2, 0, 1); s_vd = 0; cycle();
    check_eq("t3_nodest_rdy", 32'(last_rdy), 1);
    clear_stim(); commit_front(); cycle();
    set_uop(3, 4, 9, 1); cycle();
    check_eq("t3_recycled_prd", 32'(bus.out_prd), 5);

    // Flush without commit
    do_reset();
    set_uop(1, 2, 5, 1); cycle();
    set_uop(5, 2, 6, 1); cycle();
    set_uop(6, 5, 7, 1); cycle();
    clear_stim(); s_fl = 1; cycle();
    check_eq("t4_out_valid", 32'(bus.out_valid), 0);
    check_eq("t4_free", 32'(free_count), 96);
    set_uop(5, 7, 8, 1); cycle();
    check_eq("t4_prs1", 32'(bus.out_prs1), 5);
    check_eq("t4_prd", 32'(bus.out_prd), 32);

    // No-allocation uops and output stall
    set_uop(3, 4, 0, 1); cycle();
    check_eq("t5_prd", 32'(bus.out_prd), 0);
    check_eq("t5_old", 32'(bus.out_prd_old), 0);
    check_eq("t5_busy", 32'(last_busy), 0);
    set_uop(3, 4, 9, 1); s_vd = 0; cycle();
    check_eq("t5_rdv0_free", 32'(free_count), 95);
    set_uop(1, 2, 10, 1); cycle();
    set_uop(4, 4, 11, 0); cycle();
    set_uop(4, 4, 11, 0); cycle();
    check_eq("t5_hold_valid", 32'(bus.out_valid), 1);
    check_eq("t5_hold_prd", 32'(bus.out_prd), 33);

    // Commit and flush in the same cycle, then async reset mid-stall
    do_reset();
    set_uop(1, 2, 5, 1); cycle();
    set_uop(1, 2, 6, 1); cycle();
    clear_stim(); commit_front(); s_fl = 1; cycle();
    set_uop(5, 6, 8, 1); cycle();
    check_eq("t6_prs1", 32'(bus.out_prs1), 32);
    check_eq("t6_prs2", 32'(bus.out_prs2), 6);
    check_eq("t6_prd", 32'(bus.out_prd), 33);
    set_uop(1, 1, 9, 0); cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(bus.out_valid), 0);
    check_eq("t6_async_free", 32'(free_count), 96);
    check_eq("t6_async_prd", 32'(bus.out_prd), 0);
    @(posedge clk);
    #1;
    do_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      clear_stim();
      s_iv   = ($urandom % 4) != 0;
      s_rs1  = $urandom % 32;
      s_rs2  = $urandom % 32;
      s_rd   = $urandom % 32;
      s_v1   = ($urandom % 8) != 0;
      s_v2   = ($urandom % 8) != 0;
      s_vd   = ($urandom % 8) != 0;
      s_ordy = ($urandom % 4) != 0;
      if (pend_q.size() > 0 && ($urandom % 3) == 0) begin
        commit_front();
      end else if (($urandom % 50) == 0) begin
        s_cv = 1; s_crd = 0; s_cprd = $urandom % 128; s_cold = $urandom % 128;
      end
      s_fl = ($urandom % 60) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
